mcs6530_bus_master: RTL and testbench
=====================================

Name: mcs6530_bus_master

Overview:
- Bus initiator for the mcs6530 RRIOT; it is the CPU side of the bus that the mcs6530 responds to.
- Generates a free-running PHI2 from a faster system clock, which keeps the RRIOT timer running.
- Converts valid/ready read/write requests into 6502-style bus cycles: address, RS0, CS1 and R_W held across PHI1+PHI2; write data driven only in PHI2.
- Returns read data sampled at PHI2 fall, and synchronises the RRIOT IRQ line into the clk domain.

Parameters:
- PHI1_CYCLES, 2, clk cycles per bus cycle with phi2 low (>=1).
- PHI2_CYCLES, 2, clk cycles per bus cycle with phi2 high (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted on the clk edge where valid&&ready.
- req_we  input  1  1 = write, 0 = read.
- req_rs0  input  1  RS0 value for the cycle (ROM/RAM-I/O select).
- req_addr  input  10  bus address A9..A0.
- req_wdata  input  8  write data.
- rsp_valid  output  1  one-clk pulse marking completion of an accepted request.
- rsp_rdata  output  8  read data; 0 for writes.
- phi2  output  1  generated bus clock.
- r_w  output  1  1 = read, 0 = write.
- addr  output  10  bus address.
- rs0  output  1  RS0 to RRIOT.
- cs1  output  1  chip select; high only during an active cycle.
- db_o  output  8  data bus out.
- db_oe  output  1  data bus drive enable.
- db_i  input  8  data bus in.
- irq_n  input  1  RRIOT IRQ, active low, asynchronous.
- irq  output  1  synchronised active-high IRQ.

Behaviour:
- TOTAL = PHI1_CYCLES + PHI2_CYCLES. Phase counter cnt runs 0..TOTAL-1 and wraps to 0.
- phi2 is registered: 1 while cnt is in [PHI1_CYCLES, TOTAL-1], otherwise 0. It runs continuously whether or not requests are pending.
- req_ready = (cnt == TOTAL-1), combinational from cnt; it is never high while rst is asserted.
- Acceptance: on the edge where cnt == TOTAL-1 and req_valid, register addr=req_addr, rs0=req_rs0, r_w=!req_we, cs1=1, db_o=req_wdata, and set an active flag. These outputs are visible from cnt == 0 and held for the whole next bus cycle.
- Idle: at the same edge with req_valid=0, drive cs1=0 and r_w=1; addr, rs0 and db_o hold their previous values; active is cleared.
- db_oe (registered): 1 only while active && write && phi2 == 1. It is 0 during PHI1, so bus contention is impossible at a direction change.
- Completion: on the edge leaving cnt == TOTAL-1 of an active cycle:
  - Read: capture rsp_rdata = db_i.
  - Write: set rsp_rdata = 0.
  - rsp_valid = 1 for exactly the next clk (cnt == 0). It is 0 in every other clk.
- Back-to-back: completion of cycle N and acceptance of cycle N+1 occur on the same edge. Throughput is one request per TOTAL clks with no bubble.
- Latency: from the accept edge to the rsp_valid rising edge is TOTAL clks.
- req_* inputs are sampled only at the accept edge; changes at other times are ignored.
- irq: two-flop synchroniser of !irq_n, giving 2 clk latency. No latching and no acknowledge.
- Reset values (async on rst): cnt=0, phi2=0, r_w=1, cs1=0, rs0=0, addr=0, db_o=0, db_oe=0, rsp_valid=0, rsp_rdata=0, active=0, irq=0, sync flops=0.
- Reset mid-cycle: the in-flight transaction is dropped and no rsp_valid is produced. After release, the first bus cycle is idle; req_ready first rises at cnt == TOTAL-1, i.e. the 4th clk after release with default parameters.

Test Plan:
- Reset (defaults) -> all outputs at reset values. After release, phi2 follows the pattern 0,0,1,1 repeating; req_ready is high only on the 4th clk of each period.
- Write: req_we=1, req_addr=0x3C0, req_rs0=0, req_wdata=0xA5 -> next bus cycle has cs1=1, r_w=0, addr=0x3C0 across all 4 clks; db_oe=1 and db_o=0xA5 only while phi2=1; rsp_valid pulses with rsp_rdata=0.
- Read: req_we=0, req_addr=0x380, req_rs0=1; bench drives db_i=0x5A during PHI2 -> rsp_valid pulse exactly 4 clks after accept, rsp_rdata=0x5A, db_oe=0 throughout.
- Back-to-back: write 0x3C1/0x12 then read 0x3C1 with req_valid held high -> consecutive bus cycles with no idle cycle between; r_w goes 0 then 1 at the cycle boundary; two rsp_valid pulses 4 clks apart.
- Idle and mid-cycle reset: req_valid=0 -> cs1=0, r_w=1, phi2 keeps toggling. Assert rst during phi2-high of an accepted read -> no rsp_valid; outputs return to reset values immediately.
- IRQ: drive irq_n low asynchronously -> irq=1 after 2 clk edges; release irq_n -> irq=0 after 2 clk edges.

Source files
------------

// File: rtl/mcs6530_bus_master.sv
// mcs6530_bus_master
// CPU-side bus initiator for an mcs6530 RRIOT. A free-running PHI2 is derived
// from the faster system clock. Each request accepted on the valid/ready
// handshake becomes one 6502-style bus cycle: PHI1 (phi2 low) followed by
// PHI2 (phi2 high).
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in the last phase slot)
//   req_we, req_rs0,
//   req_addr, req_wdata      request contents, sampled only at the accept edge
//   rsp_valid, rsp_rdata     one-clk completion pulse, read data (0 for writes)
//   phi2                     generated bus clock
//   r_w, addr, rs0, cs1      bus control, held for a whole bus cycle
//   db_o, db_oe, db_i        data bus out, drive enable (PHI2 writes only), data in
//   irq_n, irq               asynchronous RRIOT IRQ in, synchronised active-high IRQ out
module mcs6530_bus_master #(
  parameter int PHI1_CYCLES = 2,
  parameter int PHI2_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic       req_rs0,
  input  logic [9:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       phi2,
  output logic       r_w,
  output logic [9:0] addr,
  output logic       rs0,
  output logic       cs1,
  output logic [7:0] db_o,
  output logic       db_oe,
  input  logic [7:0] db_i,
  input  logic       irq_n,
  output logic       irq
);

  localparam int TOTAL = PHI1_CYCLES + PHI2_CYCLES;
  localparam int CW = (TOTAL > 2) ? $clog2(TOTAL) : 1;
  localparam logic [CW-1:0] LAST_PHASE = CW'(TOTAL - 1);
  localparam logic [CW-1:0] PHI2_PHASE = CW'(PHI1_CYCLES);

  // Whether the bus cycle currently on the pins carries a request.
  typedef enum logic {
    BUS_IDLE   = 1'b0,
    BUS_ACTIVE = 1'b1
  } busState_t;

  busState_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phi2_q, phi2_d;
  logic          rw_q, rw_d;
  logic          cs1_q, cs1_d;
  logic          rs0_q, rs0_d;
  logic [9:0]    addr_q, addr_d;
  logic [7:0]    dbOut_q, dbOut_d;
  logic          dbOe_q, dbOe_d;
  logic          rspValid_q, rspValid_d;
  logic [7:0]    rspRdata_q, rspRdata_d;
  logic          irqMeta_q, irqSync_q;
  logic          cycleEnd;

  // The last phase slot is both the end of the current bus cycle and the only
  // moment a new request can be taken, so completion and acceptance share an edge.
  assign cycleEnd  = (cnt_q == LAST_PHASE);
  assign req_ready = cycleEnd;

  // Next-state logic. phi2 is computed from the next counter value so the
  // registered phi2 lines up with the counter. db_oe is likewise computed from
  // next-state values, which keeps it low through PHI1 at every direction change.
  always_comb begin
    cnt_d      = cycleEnd ? '0 : cnt_q + CW'(1);
    phi2_d     = (cnt_d >= PHI2_PHASE);
    state_d    = state_q;
    rw_d       = rw_q;
    cs1_d      = cs1_q;
    rs0_d      = rs0_q;
    addr_d     = addr_q;
    dbOut_d    = dbOut_q;
    rspValid_d = 1'b0;
    rspRdata_d = rspRdata_q;

    if (cycleEnd) begin
      // Read data is sampled as PHI2 falls.
      if (state_q == BUS_ACTIVE) begin
        rspValid_d = 1'b1;
        rspRdata_d = rw_q ? db_i : 8'h00;
      end
      if (req_valid) begin
        state_d = BUS_ACTIVE;
        rw_d    = !req_we;
        cs1_d   = 1'b1;
        rs0_d   = req_rs0;
        addr_d  = req_addr;
        dbOut_d = req_wdata;
      end else begin
        state_d = BUS_IDLE;
        rw_d    = 1'b1;
        cs1_d   = 1'b0;
      end
    end

    dbOe_d = (state_d == BUS_ACTIVE) && !rw_d && phi2_d;
  end

  // State register. Reset drops any in-flight transaction without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BUS_IDLE;
      cnt_q      <= '0;
      phi2_q     <= 1'b0;
      rw_q       <= 1'b1;
      cs1_q      <= 1'b0;
      rs0_q      <= 1'b0;
      addr_q     <= '0;
      dbOut_q    <= '0;
      dbOe_q     <= 1'b0;
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phi2_q     <= phi2_d;
      rw_q       <= rw_d;
      cs1_q      <= cs1_d;
      rs0_q      <= rs0_d;
      addr_q     <= addr_d;
      dbOut_q    <= dbOut_d;
      dbOe_q     <= dbOe_d;
      rspValid_q <= rspValid_d;
      rspRdata_q <= rspRdata_d;
    end
  end

  // Two-flop synchroniser for the asynchronous, active-low RRIOT IRQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irqMeta_q <= 1'b0;
      irqSync_q <= 1'b0;
    end else begin
      irqMeta_q <= !irq_n;
      irqSync_q <= irqMeta_q;
    end
  end

  assign phi2      = phi2_q;
  assign r_w       = rw_q;
  assign cs1       = cs1_q;
  assign rs0       = rs0_q;
  assign addr      = addr_q;
  assign db_o      = dbOut_q;
  assign db_oe     = dbOe_q;
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
  assign irq       = irqSync_q;

endmodule

// File: tb/tb_mcs6530_bus_master.sv
// tb_mcs6530_bus_master
// Self-checking bench for mcs6530_bus_master: directed scenarios followed by
// randomized traffic compared against a transaction-level model of the bus.
module tb_mcs6530_bus_master;

  localparam int PHI1  = 2;
  localparam int PHI2  = 2;
  localparam int TOTAL = PHI1 + PHI2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we, req_rs0;
  logic [9:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       phi2, r_w, rs0, cs1, db_oe, irq_n, irq;
  logic [9:0] addr;
  logic [7:0] db_o, db_i;

  int n;
  int testsRun  = 0;
  int failCount = 0;

  // One bus cycle as seen by the model.
  typedef struct packed {
    logic       v;
    logic       we;
    logic       rs0;
    logic [9:0] addr;
    logic [7:0] wd;
  } slot_t;

  mcs6530_bus_master #(.PHI1_CYCLES(PHI1), .PHI2_CYCLES(PHI2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_rs0(req_rs0), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .phi2(phi2), .r_w(r_w), .addr(addr), .rs0(rs0), .cs1(cs1),
    .db_o(db_o), .db_oe(db_oe), .db_i(db_i),
    .irq_n(irq_n), .irq(irq)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; the bench's own notion of bus phase.
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to a sample point in the last phase slot (the next accept opportunity).
  task automatic waitAccept();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((n % TOTAL) != TOTAL - 1 && guard < 3 * TOTAL);
    testsRun++;
    if ((n % TOTAL) != TOTAL - 1) begin
      failCount++;
      $display("[TB] FAIL wait_accept: phase %0d required %0d", n % TOTAL, TOTAL - 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_rs0 = 1'b0;
    req_addr = '0; req_wdata = '0; db_i = '0; irq_n = 1'b1;
    repeat (3) @(negedge clk);
    testsRun++;
    if ({phi2, req_ready, r_w, cs1, rs0, addr, db_o, db_oe, rsp_valid, rsp_rdata, irq} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got phi2=%b rdy=%b r_w=%b cs1=%b rs0=%b addr=%h db_o=%h oe=%b rv=%b rd=%h irq=%b",
               phi2, req_ready, r_w, cs1, rs0, addr, db_o, db_oe, rsp_valid, rsp_rdata, irq);
    end
    rst = 1'b0;
    for (int k = 0; k < 2 * TOTAL; k++) begin
      @(negedge clk);
      testsRun++;
      if (phi2 !== ((n % TOTAL) >= PHI1) || req_ready !== ((n % TOTAL) == TOTAL - 1) ||
          cs1 !== 1'b0 || r_w !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL reset_release_pattern clk=%0d: got phi2=%b rdy=%b cs1=%b r_w=%b required phi2=%b rdy=%b cs1=0 r_w=1",
                 n, phi2, req_ready, cs1, r_w, (n % TOTAL) >= PHI1, (n % TOTAL) == TOTAL - 1);
      end
    end
  endtask

  task automatic test_write();
    waitAccept();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h3C0; req_rs0 = 1'b0; req_wdata = 8'hA5;
    db_i = 8'hFF;
    for (int p = 0; p < TOTAL; p++) begin
      @(negedge clk);
      req_valid = 1'b0; req_wdata = 8'h00; req_addr = 10'h000;
      testsRun++;
      if (cs1 !== 1'b1 || r_w !== 1'b0 || addr !== 10'h3C0 || rs0 !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL write_bus_hold p=%0d: got cs1=%b r_w=%b addr=%h rs0=%b required 1 0 3c0 0",
                 p, cs1, r_w, addr, rs0);
      end
      testsRun++;
      if (db_oe !== (p >= PHI1) || (phi2 === 1'b1 && db_o !== 8'hA5)) begin
        failCount++;
        $display("[TB] FAIL write_db_drive p=%0d: got oe=%b db_o=%h required oe=%b db_o=a5",
                 p, db_oe, db_o, p >= PHI1);
      end
      if (p > 0) begin
        testsRun++;
        if (rsp_valid !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL write_rsp_early p=%0d: got %b required 0", p, rsp_valid);
        end
      end
    end
    @(negedge clk);
    testsRun++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL write_rsp: got valid=%b rdata=%h required 1 00", rsp_valid, rsp_rdata);
    end
    testsRun++;
    if (cs1 !== 1'b0 || r_w !== 1'b1 || addr !== 10'h3C0 || db_oe !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL write_idle_after: got cs1=%b r_w=%b addr=%h oe=%b required 0 1 3c0 0",
               cs1, r_w, addr, db_oe);
    end
  endtask

  task automatic test_read();
    waitAccept();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h380; req_rs0 = 1'b1; req_wdata = 8'h00;
    db_i = 8'hC3;
    for (int p = 0; p < TOTAL; p++) begin
      @(negedge clk);
      req_valid = 1'b0; req_rs0 = 1'b0;
      db_i = (p >= PHI1) ? 8'h5A : 8'hC3;
      testsRun++;
      if (cs1 !== 1'b1 || r_w !== 1'b1 || addr !== 10'h380 || rs0 !== 1'b1 || db_oe !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL read_bus_hold p=%0d: got cs1=%b r_w=%b addr=%h rs0=%b oe=%b required 1 1 380 1 0",
                 p, cs1, r_w, addr, rs0, db_oe);
      end
      if (p > 0) begin
        testsRun++;
        if (rsp_valid !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL read_rsp_early p=%0d: got %b required 0", p, rsp_valid);
        end
      end
    end
    @(negedge clk);
    db_i = 8'h00;
    testsRun++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h5A) begin
      failCount++;
      $display("[TB] FAIL read_rsp: got valid=%b rdata=%h required 1 5a", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    testsRun++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h5A) begin
      failCount++;
      $display("[TB] FAIL read_rsp_single_pulse: got valid=%b rdata=%h required 0 5a", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    waitAccept();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h3C1; req_rs0 = 1'b0; req_wdata = 8'h12;
    db_i = 8'h00;
    for (int p = 0; p < TOTAL; p++) begin
      @(negedge clk);
      testsRun++;
      if (r_w !== 1'b0 || cs1 !== 1'b1 || addr !== 10'h3C1 || db_o !== 8'h12) begin
        failCount++;
        $display("[TB] FAIL b2b_write_bus p=%0d: got r_w=%b cs1=%b addr=%h db_o=%h required 0 1 3c1 12",
                 p, r_w, cs1, addr, db_o);
      end
      if (p > 0) begin
        testsRun++;
        if (rsp_valid !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL b2b_rsp_gap1 p=%0d: got %b required 0", p, rsp_valid);
        end
      end
      if (p == TOTAL - 1) begin
        req_we = 1'b0; req_addr = 10'h3C1;
      end
    end
    for (int p = 0; p < TOTAL; p++) begin
      @(negedge clk);
      if (p == 0) begin
        testsRun++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00) begin
          failCount++;
          $display("[TB] FAIL b2b_first_rsp: got valid=%b rdata=%h required 1 00", rsp_valid, rsp_rdata);
        end
      end else begin
        testsRun++;
        if (rsp_valid !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL b2b_rsp_gap2 p=%0d: got %b required 0", p, rsp_valid);
        end
      end
      testsRun++;
      if (r_w !== 1'b1 || cs1 !== 1'b1 || addr !== 10'h3C1 || db_oe !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL b2b_read_bus p=%0d: got r_w=%b cs1=%b addr=%h oe=%b required 1 1 3c1 0",
                 p, r_w, cs1, addr, db_oe);
      end
      db_i = (p >= PHI1) ? 8'h77 : 8'h00;
      if (p == TOTAL - 1) req_valid = 1'b0;
    end
    @(negedge clk);
    testsRun++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h77 || cs1 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_second_rsp: got valid=%b rdata=%h cs1=%b required 1 77 0", rsp_valid, rsp_rdata, cs1);
    end
  endtask

  task automatic test_idle();
    waitAccept();
    for (int k = 0; k < 2 * TOTAL; k++) begin
      @(negedge clk);
      testsRun++;
      if (cs1 !== 1'b0 || r_w !== 1'b1 || db_oe !== 1'b0 || rsp_valid !== 1'b0 ||
          phi2 !== ((n % TOTAL) >= PHI1)) begin
        failCount++;
        $display("[TB] FAIL idle_bus clk=%0d: got cs1=%b r_w=%b oe=%b rv=%b phi2=%b required 0 1 0 0 %b",
                 n, cs1, r_w, db_oe, rsp_valid, phi2, (n % TOTAL) >= PHI1);
      end
      req_valid = 1'b0;
      req_we = 1'($urandom); req_rs0 = 1'($urandom);
      req_addr = 10'($urandom); req_wdata = 8'($urandom);
    end
    testsRun++;
    if (addr !== 10'h3C1 || db_o !== 8'h12) begin
      failCount++;
      $display("[TB] FAIL idle_hold: got addr=%h db_o=%h required 3c1 12", addr, db_o);
    end
  endtask

  task automatic test_mid_reset();
    waitAccept();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h155; req_rs0 = 1'b1; req_wdata = 8'h00;
    db_i = 8'h99;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (PHI1) @(negedge clk);
    testsRun++;
    if (cs1 !== 1'b1 || phi2 !== 1'b1 || addr !== 10'h155) begin
      failCount++;
      $display("[TB] FAIL midrst_active: got cs1=%b phi2=%b addr=%h required 1 1 155", cs1, phi2, addr);
    end
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if ({phi2, req_ready, r_w, cs1, rs0, addr, db_o, db_oe, rsp_valid, rsp_rdata, irq} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL midrst_async: got phi2=%b rdy=%b r_w=%b cs1=%b rs0=%b addr=%h oe=%b rv=%b rd=%h",
               phi2, req_ready, r_w, cs1, rs0, addr, db_oe, rsp_valid, rsp_rdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2 * TOTAL; k++) begin
      @(negedge clk);
      testsRun++;
      if (rsp_valid !== 1'b0 || cs1 !== 1'b0 || phi2 !== ((n % TOTAL) >= PHI1) ||
          req_ready !== ((n % TOTAL) == TOTAL - 1)) begin
        failCount++;
        $display("[TB] FAIL midrst_after clk=%0d: got rv=%b cs1=%b phi2=%b rdy=%b required 0 0 %b %b",
                 n, rsp_valid, cs1, phi2, req_ready, (n % TOTAL) >= PHI1, (n % TOTAL) == TOTAL - 1);
      end
    end
  endtask

  task automatic test_irq();
    @(negedge clk);
    #2 irq_n = 1'b0;
    @(posedge clk); #1;
    testsRun++;
    if (irq !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL irq_assert_edge1: got %b required 0", irq);
    end
    @(posedge clk); #1;
    testsRun++;
    if (irq !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL irq_assert_edge2: got %b required 1", irq);
    end
    @(negedge clk);
    #3 irq_n = 1'b1;
    @(posedge clk); #1;
    testsRun++;
    if (irq !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL irq_release_edge1: got %b required 1", irq);
    end
    @(posedge clk); #1;
    testsRun++;
    if (irq !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL irq_release_edge2: got %b required 0", irq);
    end
  endtask

  // Random traffic against a transaction model: each bus cycle carries the
  // request offered in the last slot of the previous cycle; its response
  // appears in the first slot of the following cycle.
  task automatic test_random();
    slot_t       cur, nxt;
    logic        pendRsp, expRsp, lastRs0;
    logic [7:0]  pendData, expRdata, lastWd;
    logic [9:0]  lastAddr;
    logic [32:0] expVec, gotVec;
    int          p;
    cur = '0; lastAddr = '0; lastRs0 = 1'b0; lastWd = '0; expRdata = '0;
    waitAccept();
    req_valid = ($urandom_range(0, 3) != 0); req_we = 1'($urandom); req_rs0 = 1'($urandom);
    req_addr = 10'($urandom); req_wdata = 8'($urandom); db_i = 8'($urandom);
    nxt = {req_valid, req_we, req_rs0, req_addr, req_wdata};
    pendRsp = 1'b0; pendData = '0;
    for (int k = 0; k < 150 * TOTAL; k++) begin
      @(negedge clk);
      p = n % TOTAL;
      expRsp = 1'b0;
      if (p == 0) begin
        cur = nxt;
        if (cur.v) begin
          lastAddr = cur.addr; lastRs0 = cur.rs0; lastWd = cur.wd;
        end
        expRsp = pendRsp;
        if (pendRsp) expRdata = pendData;
      end
      expVec = {p >= PHI1, p == TOTAL - 1, cur.v, !(cur.v && cur.we), lastRs0, lastAddr,
                lastWd, cur.v && cur.we && (p >= PHI1), expRsp, expRdata};
      gotVec = {phi2, req_ready, cs1, r_w, rs0, addr, db_o, db_oe, rsp_valid, rsp_rdata};
      testsRun++;
      if (gotVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL random_bus clk=%0d phase=%0d: got %h required %h", n, p, gotVec, expVec);
      end
      req_valid = ($urandom_range(0, 3) != 0); req_we = 1'($urandom); req_rs0 = 1'($urandom);
      req_addr = 10'($urandom); req_wdata = 8'($urandom); db_i = 8'($urandom);
      if (p == TOTAL - 1) begin
        nxt      = {req_valid, req_we, req_rs0, req_addr, req_wdata};
        pendRsp  = cur.v;
        pendData = cur.we ? 8'h00 : db_i;
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_idle();
    test_mid_reset();
    test_irq();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
